uart_reg_responder: RTL
=======================

// Module: uart_reg_responder
// PURPOSE
// - Command responder on the far side of the UART byte link. It consumes bytes from
//   the receiver, parses binary read/write frames and updates a 16x8 register file.
//   It returns one response byte per frame to the transmitter.
// - Sits between receiver (byte out) and transmitter (byte in) inside the UART top level.
// PARAMETERS
// - ADDR_W       4          register address width; REG_DEPTH = 2**ADDR_W
// - TIMEOUT_CYC  1_000_000  sys_clk cycles of inter-byte silence that abort a partial frame
// - ACK_BYTE     8'hAC      response to a successful write
// - NAK_BYTE     8'hEE      response to a bad opcode or a bad checksum
// PORTS
// - sys_clk    in   1       system clock, rising edge
// - rst        in   1       asynchronous, active-low reset
// - rx_byte    in   8       received byte, valid only when rx_valid=1
// - rx_valid   in   1       one-cycle pulse per received byte
// - tx_byte    out  8       response byte, held stable while tx_valid=1
// - tx_valid   out  1       response pending
// - tx_ready   in   1       transmitter idle; byte accepted when tx_valid & tx_ready
// - ctrl_out   out  8       live copy of register 0 (drives LEDs)
// - overrun    out  1       sticky; byte arrived while a response was pending
// - busy       out  1       1 when state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; all registers 0x00; tx_byte=0; tx_valid=0;
//   overrun=0; ctrl_out=0; busy=0; timeout counter=0.
// - Frames:
//   - Write: 8'hA5, addr, data.
//   - Read: 8'h5A, addr.
//   - Only addr[ADDR_W-1:0] is used; upper bits are ignored (no error).
// - FSM: IDLE -> GET_ADDR -> [GET_DATA] -> [GET_CSUM] -> EXEC -> SEND -> IDLE.
//   - IDLE, rx_valid:
//     - opcode A5 or 5A -> GET_ADDR.
//     - any other opcode -> SEND with tx_byte=NAK_BYTE.
//   - GET_ADDR, rx_valid: write -> GET_DATA; read -> EXEC (or GET_CSUM if enabled).
//   - GET_DATA, rx_valid: -> EXEC (or GET_CSUM if enabled).
//   - EXEC, one cycle:
//     - Write: regs[addr] <= data; tx_byte <= ACK_BYTE.
//     - Read: tx_byte <= regs[addr].
//   - SEND: tx_valid=1 and held until tx_ready=1 in the same cycle; next cycle
//     tx_valid=0 and state=IDLE.
// - Latency:
//   - The final frame byte's rx_valid cycle is cycle N.
//   - Register write and tx_byte load happen at N+1.
//   - tx_valid rises at N+2.
//   - ctrl_out reflects a write to addr 0 from N+2.
// - Read-after-write in back-to-back frames returns the new value.
// - Timeout: the counter clears on every rx_valid and runs in GET_ADDR, GET_DATA and
//   GET_CSUM. At TIMEOUT_CYC-1 the FSM goes to IDLE with no response and no write.
//   The counter never runs in IDLE, EXEC or SEND.
// - rx_valid during EXEC or SEND: the byte is dropped, overrun<=1 (sticky until reset),
//   and the pending response is unaffected.
// - rx_valid and a timeout in the same cycle: the byte wins and the counter clears.
// - tx_ready already high on tx_valid's first cycle: one-cycle handshake, legal.
// - Reset mid-frame or mid-SEND: immediate abort; tx_valid drops asynchronously;
//   no partial write.
// CONFIGURATION
// - UART_RESP_CHECKSUM_EN defined:
//   - Every frame carries a trailing byte equal to the XOR of all preceding frame bytes.
//   - GET_CSUM receives it.
//   - Mismatch -> no register write; tx_byte=NAK_BYTE.
//   - Match -> normal EXEC.
//   - Latency is counted from the checksum byte.
// - Not defined: no checksum byte; GET_CSUM is not built.
// TESTING
// - Reset then write A5,03,3C -> tx_byte=AC with one tx_valid pulse; read 5A,03 -> 3C.
// - Write A5,00,81 -> ctrl_out=81 at N+2; regs 1..15 still read 00.
// - Opcode 7F -> NAK EE; next frame 5A,00 parses normally.
// - A5,05 then silence for TIMEOUT_CYC -> no response, busy=0; a read of 5 returns 00.
// - Hold tx_ready=0 for 50 cycles during SEND and inject rx_valid -> tx_byte stable,
//   overrun=1, exactly one transfer after tx_ready=1.
// - UART_RESP_CHECKSUM_EN:
//   - A5,02,55,F2 -> AC; the register is written.
//   - A5,02,55,00 -> EE; the register is unchanged.

Source files
------------

// File: rtl/uart_reg_responder_if.sv
// Byte link between the UART receiver/transmitter pair and the register responder.
// The master side drives received bytes and transmitter readiness; the slave side
// (the responder) returns one response byte per frame with a valid/ready handshake.
interface uart_reg_responder_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output rx_byte,
        output rx_valid,
        output tx_ready,
        input  tx_byte,
        input  tx_valid
    );

    modport slave (
        input  rx_byte,
        input  rx_valid,
        input  tx_ready,
        output tx_byte,
        output tx_valid
    );
endinterface

// File: rtl/uart_reg_responder.sv
// Register-file command responder behind the UART byte link.
// Frames: write = A5, addr, data; read = 5A, addr. One response byte per frame:
// ACK_BYTE after a write, the register value after a read, NAK_BYTE on a bad opcode.
// A partial frame is abandoned after TIMEOUT_CYC cycles of inter-byte silence.
// Optional feature: define UART_RESP_CHECKSUM_EN to require a trailing XOR checksum
// byte on every frame; a mismatch suppresses the write and answers NAK_BYTE.
module uart_reg_responder #(
    parameter int         ADDR_W      = 4,
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] ACK_BYTE    = 8'hAC,
    parameter logic [7:0] NAK_BYTE    = 8'hEE
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    uart_reg_responder_if.slave        link,
    output logic [7:0]                 ctrl_out,
    output logic                       overrun,
    output logic                       busy
);

    localparam int REG_DEPTH = 1 << ADDR_W;
    localparam int CNT_W     = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0] OP_WRITE = 8'hA5;
    localparam logic [7:0] OP_READ  = 8'h5A;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
`ifdef UART_RESP_CHECKSUM_EN
        GET_CSUM,
`endif
        EXEC,
        SEND
    } state_t;

    // After the last address/data byte the frame either ends or waits for its checksum.
`ifdef UART_RESP_CHECKSUM_EN
    localparam state_t AFTER_FIELDS = GET_CSUM;
`else
    localparam state_t AFTER_FIELDS = EXEC;
`endif

    state_t            state;
    state_t            state_next;
    logic [7:0]        regs [REG_DEPTH];
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              is_write;
    logic [7:0]        resp;
    logic [CNT_W-1:0]  idle_cnt;
    logic              collecting;
    logic              timed_out;
    logic              opcode_ok;
`ifdef UART_RESP_CHECKSUM_EN
    logic [7:0]        csum_acc;
    logic              csum_bad;
`endif

    assign opcode_ok     = (link.rx_byte == OP_WRITE) || (link.rx_byte == OP_READ);
    assign timed_out     = collecting && !link.rx_valid && (idle_cnt == CNT_LAST);
    assign link.tx_byte  = resp;
    assign ctrl_out      = regs[0];

    // State register; reset aborts any frame or pending response immediately.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a received byte always beats a timeout in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (link.rx_valid) begin
                    state_next = opcode_ok ? GET_ADDR : SEND;
                end
            end
            GET_ADDR: begin
                if (link.rx_valid) begin
                    state_next = is_write ? GET_DATA : AFTER_FIELDS;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
            GET_DATA: begin
                if (link.rx_valid) begin
                    state_next = AFTER_FIELDS;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
`ifdef UART_RESP_CHECKSUM_EN
            GET_CSUM: begin
                if (link.rx_valid) begin
                    state_next = EXEC;
                end else if (timed_out) begin
                    state_next = IDLE;
                end
            end
`endif
            EXEC: state_next = SEND;
            SEND: begin
                if (link.tx_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded outputs: response valid only in SEND, silence timer only mid-frame.
    always_comb begin
        link.tx_valid = (state == SEND);
        busy          = (state != IDLE);
        collecting    = (state == GET_ADDR) || (state == GET_DATA)
`ifdef UART_RESP_CHECKSUM_EN
                        || (state == GET_CSUM)
`endif
                        ;
    end

    // Inter-byte silence counter: cleared by every byte and whenever no frame is open.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (link.rx_valid || !collecting || (idle_cnt == CNT_LAST)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    // Frame capture, register file update and response byte load.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                regs[i] <= '0;
            end
            addr     <= '0;
            data     <= '0;
            is_write <= 1'b0;
            resp     <= '0;
            overrun  <= 1'b0;
`ifdef UART_RESP_CHECKSUM_EN
            csum_acc <= '0;
            csum_bad <= 1'b0;
`endif
        end else begin
            if (link.rx_valid) begin
                case (state)
                    IDLE: begin
                        is_write <= (link.rx_byte == OP_WRITE);
`ifdef UART_RESP_CHECKSUM_EN
                        csum_acc <= link.rx_byte;
`endif
                        if (!opcode_ok) begin
                            resp <= NAK_BYTE;
                        end
                    end
                    GET_ADDR: begin
                        addr <= link.rx_byte[ADDR_W-1:0];
`ifdef UART_RESP_CHECKSUM_EN
                        csum_acc <= csum_acc ^ link.rx_byte;
`endif
                    end
                    GET_DATA: begin
                        data <= link.rx_byte;
`ifdef UART_RESP_CHECKSUM_EN
                        csum_acc <= csum_acc ^ link.rx_byte;
`endif
                    end
`ifdef UART_RESP_CHECKSUM_EN
                    GET_CSUM: begin
                        csum_bad <= (link.rx_byte != csum_acc);
                    end
`endif
                    default: begin
                        overrun <= 1'b1;
                    end
                endcase
            end
            if (state == EXEC) begin
`ifdef UART_RESP_CHECKSUM_EN
                if (csum_bad) begin
                    resp <= NAK_BYTE;
                end else
`endif
                if (is_write) begin
                    regs[addr] <= data;
                    resp       <= ACK_BYTE;
                end else begin
                    resp <= regs[addr];
                end
            end
        end
    end

endmodule
